// File: rtl/roi_frame_sequencer_if.sv
// ROI stream bundle between the frame sequencer (master) and the downstream consumer (slave).
interface roi_frame_sequencer_if;
  logic        roi_valid;
  logic [39:0] roi_data;
  logic [3:0]  roi_index;
  logic        roi_last;
  logic        roi_ready;

  modport master (
    output roi_valid, roi_data, roi_index, roi_last,
    input  roi_ready
  );

  modport slave (
    input  roi_valid, roi_data, roi_index, roi_last,
    output roi_ready
  );
endinterface

// File: rtl/roi_frame_sequencer.sv
// Ping-pong frame sequencer: swaps camera/finder BRAM banks, starts the spot finder and streams its ROIs.
// Optional analysis watchdog enabled by defining ROI_SEQ_WATCHDOG_EN.
module roi_frame_sequencer #(
  parameter int NUM_ROIS_MAX   = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       frame_done,
  output logic                       cam_bank,
  output logic                       finder_bank,
  output logic                       finder_reset,
  input  logic                       analysis_rdy,
  input  logic [5:0]                 num_rois,
  input  logic [NUM_ROIS_MAX*40-1:0] rois_in,
  roi_frame_sequencer_if.master      roi,
  output logic                       frame_complete,
  output logic [15:0]                drop_count,
  output logic                       timeout_err
);

  typedef enum logic [2:0] {IDLE, START, ANALYZE, LATCH, SEND, DONE} state_t;

  state_t                     state;
  logic                       armed;
  logic [5:0]                 count;
  logic [NUM_ROIS_MAX*40-1:0] rois_latched;
  logic [5:0]                 clamped;
  logic [3:0]                 next_index;
  logic                       accept;
  logic                       busy;

`ifdef ROI_SEQ_WATCHDOG_EN
  localparam int WdWidth = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdWidth-1:0] wd_count;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    clamped    = (num_rois > 6'(NUM_ROIS_MAX)) ? 6'(NUM_ROIS_MAX) : num_rois;
    next_index = roi.roi_index + 4'd1;
    accept     = frame_done && (state == IDLE || state == DONE);
    busy       = (state == START) || (state == ANALYZE) || (state == LATCH) || (state == SEND);
  end

  // A frame_done arriving in IDLE or DONE wins over DONE's return to IDLE, so it is applied after the case.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state          <= IDLE;
      cam_bank       <= 1'b0;
      finder_bank    <= 1'b0;
      finder_reset   <= 1'b0;
      roi.roi_valid  <= 1'b0;
      roi.roi_data   <= '0;
      roi.roi_index  <= '0;
      roi.roi_last   <= 1'b0;
      frame_complete <= 1'b0;
      drop_count     <= '0;
      armed          <= 1'b0;
      count          <= '0;
`ifdef ROI_SEQ_WATCHDOG_EN
      timeout_err    <= 1'b0;
      wd_count       <= '0;
`endif
    end else begin
      case (state)
        IDLE: ;
        START: begin
          finder_reset <= 1'b0;
          armed        <= 1'b0;
`ifdef ROI_SEQ_WATCHDOG_EN
          wd_count     <= '0;
`endif
          state        <= ANALYZE;
        end
        ANALYZE: begin
          // The finder's ready level may still be high from the previous frame; wait to see it low first.
          if (armed && analysis_rdy) begin
            state <= LATCH;
          end
`ifdef ROI_SEQ_WATCHDOG_EN
          else if (wd_count == WdWidth'(TIMEOUT_CYCLES - 1)) begin
            timeout_err    <= 1'b1;
            frame_complete <= 1'b1;
            state          <= DONE;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
`endif
          if (!analysis_rdy) armed <= 1'b1;
        end
        LATCH: begin
          rois_latched  <= rois_in;
          count         <= clamped;
          roi.roi_index <= '0;
          if (clamped == 6'd0) begin
            frame_complete <= 1'b1;
            state          <= DONE;
          end else begin
            roi.roi_valid <= 1'b1;
            roi.roi_data  <= rois_in[39:0];
            roi.roi_last  <= (clamped == 6'd1);
            state         <= SEND;
          end
        end
        SEND: begin
          if (roi.roi_ready) begin
            if (roi.roi_last) begin
              roi.roi_valid  <= 1'b0;
              roi.roi_last   <= 1'b0;
              frame_complete <= 1'b1;
              state          <= DONE;
            end else begin
              roi.roi_index <= next_index;
              roi.roi_data  <= rois_latched[int'(next_index)*40 +: 40];
              roi.roi_last  <= ({2'b00, next_index} == count - 6'd1);
            end
          end
        end
        DONE: begin
          frame_complete <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        finder_bank  <= cam_bank;
        cam_bank     <= ~cam_bank;
        finder_reset <= 1'b1;
        state        <= START;
      end

      if (frame_done && busy && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_roi_frame_sequencer.sv
// Directed scoreboard bench for roi_frame_sequencer; watchdog section active when ROI_SEQ_WATCHDOG_EN is defined.
module tb_roi_frame_sequencer;

`ifdef ROI_SEQ_WATCHDOG_EN
  localparam int TimeoutCycles = 100;
`else
  localparam int TimeoutCycles = 1000000;
`endif

  typedef struct packed {
    logic [3:0]  idx;
    logic [39:0] data;
    logic        last;
  } beat_t;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         frame_done;
  logic         cam_bank;
  logic         finder_bank;
  logic         finder_reset;
  logic         analysis_rdy;
  logic [5:0]   num_rois;
  logic [399:0] rois_in;
  logic         frame_complete;
  logic [15:0]  drop_count;
  logic         timeout_err;

  roi_frame_sequencer_if roi ();

  roi_frame_sequencer #(
    .NUM_ROIS_MAX  (10),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .frame_done    (frame_done),
    .cam_bank      (cam_bank),
    .finder_bank   (finder_bank),
    .finder_reset  (finder_reset),
    .analysis_rdy  (analysis_rdy),
    .num_rois      (num_rois),
    .rois_in       (rois_in),
    .roi           (roi.master),
    .frame_complete(frame_complete),
    .drop_count    (drop_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          errors = 0;
  int          beatCount = 0;
  beat_t       expQ[$];
  logic        modelCam = 1'b0;
  logic        modelFinder = 1'b0;
  logic [39:0] holdData;
  logic [3:0]  holdIdx;
  logic        holdCam;
  logic        holdFinder;
  logic        found;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus: inputs change just after a rising edge, frame_done is a single-cycle pulse.
  task automatic applyStimulus(input logic fd, input logic rdy);
    frame_done   = fd;
    analysis_rdy = rdy;
    @(posedge clk_in);
    #1;
    frame_done = 1'b0;
  endtask

  task automatic expectFrameStart();
    modelFinder = modelCam;
    modelCam    = ~modelCam;
    checkOutput("cam_bank", cam_bank, modelCam);
    checkOutput("finder_bank", finder_bank, modelFinder);
    checkOutput("finder_reset_pulse", finder_reset, 1);
  endtask

  task automatic pushFrame(input int n);
    int cnt;
    beat_t b;
    cnt = (n > 10) ? 10 : n;
    for (int i = 0; i < cnt; i++) begin
      b.idx  = 4'(i);
      b.data = rois_in[40*i +: 40];
      b.last = (i == cnt - 1);
      expQ.push_back(b);
    end
  endtask

  task automatic waitForComplete(input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (frame_complete) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("frame_complete_seen", seen, 1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic waitForBeat(input logic [3:0] idx);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (roi.roi_valid && roi.roi_index == idx) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("beat_reached", found, 1);
  endtask

  // Every accepted beat is popped from the scoreboard and compared.
  always @(negedge clk_in) begin
    if (roi.roi_valid && roi.roi_ready) begin
      beat_t e;
      beatCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("beat_index", roi.roi_index, e.idx);
        checkOutput("beat_data", roi.roi_data, e.data);
        checkOutput("beat_last", roi.roi_last, e.last);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    reset        = 1'b1;
    frame_done   = 1'b0;
    analysis_rdy = 1'b0;
    num_rois     = 6'd0;
    roi.roi_ready = 1'b1;
    for (int i = 0; i < 10; i++) rois_in[40*i +: 40] = {8'($urandom), 32'($urandom)};

    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("rst_cam_bank", cam_bank, 0);
    checkOutput("rst_finder_bank", finder_bank, 0);
    checkOutput("rst_finder_reset", finder_reset, 0);
    checkOutput("rst_roi_valid", roi.roi_valid, 0);
    checkOutput("rst_roi_data", roi.roi_data, 0);
    checkOutput("rst_roi_index", roi.roi_index, 0);
    checkOutput("rst_roi_last", roi.roi_last, 0);
    checkOutput("rst_frame_complete", frame_complete, 0);
    checkOutput("rst_drop_count", drop_count, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;

    // Basic frame: three ROIs, finder ready after ~50 cycles.
    num_rois = 6'd3;
    applyStimulus(1'b1, 1'b0);
    expectFrameStart();
    applyStimulus(1'b0, 1'b0);
    checkOutput("finder_reset_one_cycle", finder_reset, 0);
    repeat (48) applyStimulus(1'b0, 1'b0);
    beatCount = 0;
    pushFrame(3);
    applyStimulus(1'b0, 1'b1);
    checkOutput("valid_latency_early", roi.roi_valid, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("valid_latency", roi.roi_valid, 1);
    waitForComplete(20);
    checkOutput("beats_frame3", beatCount, 3);
    checkOutput("queue_empty_frame3", expQ.size(), 0);

    // Stale ready level from the previous frame must be ignored until it drops.
    num_rois = 6'd2;
    applyStimulus(1'b1, 1'b1);
    expectFrameStart();
    beatCount = 0;
    repeat (10) applyStimulus(1'b0, 1'b1);
    checkOutput("stale_rdy_ignored", roi.roi_valid, 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pushFrame(2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rearm_latency_early", roi.roi_valid, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rearm_latency", roi.roi_valid, 1);
    waitForComplete(20);
    checkOutput("beats_frame2", beatCount, 2);

    // Zero ROIs: frame completes two cycles after the ready rise, no beats.
    num_rois = 6'd0;
    applyStimulus(1'b1, 1'b1);
    expectFrameStart();
    beatCount = 0;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("zero_complete_early", frame_complete, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("zero_complete", frame_complete, 1);
    checkOutput("zero_no_beats", beatCount, 0);
    applyStimulus(1'b0, 1'b1);

    // Twelve ROIs requested: clamped to ten.
    num_rois = 6'd12;
    applyStimulus(1'b1, 1'b1);
    expectFrameStart();
    beatCount = 0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pushFrame(12);
    applyStimulus(1'b0, 1'b1);
    waitForComplete(40);
    checkOutput("beats_clamped", beatCount, 10);
    checkOutput("queue_empty_clamped", expQ.size(), 0);
    checkOutput("no_drops_yet", drop_count, 0);

    // Backpressure on beat 1 with dropped frames and late input changes.
    num_rois = 6'd4;
    applyStimulus(1'b1, 1'b1);
    expectFrameStart();
    beatCount = 0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pushFrame(4);
    waitForBeat(4'd1);
    roi.roi_ready = 1'b0;
    holdData   = roi.roi_data;
    holdIdx    = roi.roi_index;
    holdCam    = cam_bank;
    holdFinder = finder_bank;
    rois_in    = ~rois_in;
    num_rois   = 6'd1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k < 3, 1'b1);
      checkOutput("stall_data_stable", roi.roi_data, holdData);
      checkOutput("stall_index_stable", roi.roi_index, holdIdx);
    end
    checkOutput("drop_count_3", drop_count, 3);
    checkOutput("drop_cam_bank", cam_bank, holdCam);
    checkOutput("drop_finder_bank", finder_bank, holdFinder);
    roi.roi_ready = 1'b1;
    waitForComplete(20);
    checkOutput("beats_stall", beatCount, 4);
    checkOutput("queue_empty_stall", expQ.size(), 0);

    // Reset during beat 2 aborts the frame; frame_done under reset is ignored.
    num_rois = 6'd5;
    applyStimulus(1'b1, 1'b1);
    expectFrameStart();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pushFrame(5);
    waitForBeat(4'd2);
    roi.roi_ready = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rst_roi_valid", roi.roi_valid, 0);
    checkOutput("mid_rst_roi_data", roi.roi_data, 0);
    checkOutput("mid_rst_roi_index", roi.roi_index, 0);
    checkOutput("mid_rst_roi_last", roi.roi_last, 0);
    checkOutput("mid_rst_cam_bank", cam_bank, 0);
    checkOutput("mid_rst_finder_bank", finder_bank, 0);
    checkOutput("mid_rst_drop_count", drop_count, 0);
    checkOutput("mid_rst_frame_complete", frame_complete, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_fd_ignored", drop_count, 0);
    expQ.delete();
    modelCam    = 1'b0;
    modelFinder = 1'b0;
    reset = 1'b0;
    roi.roi_ready = 1'b1;
    num_rois = 6'd1;
    applyStimulus(1'b1, 1'b1);
    expectFrameStart();
    beatCount = 0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    pushFrame(1);
    applyStimulus(1'b0, 1'b1);
    waitForComplete(20);
    checkOutput("beats_after_reset", beatCount, 1);

`ifdef ROI_SEQ_WATCHDOG_EN
    // Finder never reports ready: watchdog ends the frame with no ROIs.
    applyStimulus(1'b1, 1'b0);
    expectFrameStart();
    beatCount = 0;
    applyStimulus(1'b0, 1'b0);
    waitForComplete(150);
    checkOutput("watchdog_timeout_err", timeout_err, 1);
    checkOutput("watchdog_no_beats", beatCount, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("watchdog_sticky", timeout_err, 1);
`else
    checkOutput("timeout_err_tied", timeout_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/roi_frame_sequencer.md
ROI_FRAME_SEQUENCER -- requirements
Module: roi_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROIS_MAX, default 10, max ROIs per frame accepted from the spot finder.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, analysis watchdog limit (used only with ROI_SEQ_WATCHDOG_EN).
REQ-003 SHALL have clk_in  input  1  clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have frame_done  input  1  one-cycle pulse: camera writer finished a frame into bank cam_bank.
REQ-006 SHALL have cam_bank  output  1  BRAM bank the camera writer SHALL fill.
REQ-007 SHALL have finder_bank  output  1  BRAM bank the spot finder SHALL read.
REQ-008 SHALL have finder_reset  output  1  one-cycle start pulse to the spot finder reset input.
REQ-009 SHALL have analysis_rdy  input  1  spot finder completion level.
REQ-010 SHALL have num_rois  input  6  ROI count from the spot finder.
REQ-011 SHALL have rois_in  input  NUM_ROIS_MAX*40  packed ROIs; ROI i at bits [40*i +: 40], {x_start,y_start,x_end,y_end}, 10 bits each, x_start in MSBs.
REQ-012 SHALL have roi_valid  output  1, roi_data  output  40, roi_index  output  4, roi_last  output  1: ROI stream.
REQ-013 SHALL have roi_ready  input  1  downstream accept.
REQ-014 SHALL have frame_complete  output  1  one-cycle pulse after a frame's ROIs are fully sent; drop_count  output  16  dropped frames; timeout_err  output  1  sticky watchdog flag.

Function
REQ-015 SHALL implement states IDLE, START, ANALYZE, LATCH, SEND, DONE.
REQ-016 IDLE or DONE with frame_done=1: finder_bank<=cam_bank, cam_bank<=~cam_bank, next state START.
REQ-017 frame_done in START, ANALYZE, LATCH or SEND SHALL leave banks unchanged and increment drop_count, saturating at 16'hFFFF.
REQ-018 START SHALL last exactly one cycle with finder_reset=1; finder_reset SHALL be 0 in all other states.
REQ-019 ANALYZE SHALL ignore analysis_rdy until it has sampled analysis_rdy=0 at least once (stale level from previous frame), then on analysis_rdy=1 go to LATCH.
REQ-020 LATCH (one cycle) SHALL register rois_in and count=min(num_rois, NUM_ROIS_MAX), clear index to 0; count=0 -> DONE, else -> SEND.
REQ-021 SEND SHALL drive roi_valid=1, roi_data=latched ROI[index], roi_index=index, roi_last=(index==count-1); outputs SHALL stay stable until roi_valid&&roi_ready.
REQ-022 On handshake with roi_last=0 index SHALL increment; with roi_last=1 next state DONE, roi_valid=0 in the following cycle.
REQ-023 DONE SHALL last one cycle with frame_complete=1, then IDLE unless REQ-016 applies.
REQ-024 Changes to rois_in/num_rois after LATCH SHALL NOT affect the stream.
REQ-025 Latency frame_done(IDLE) -> finder_reset = 1 cycle; analysis_rdy rise (armed) -> first roi_valid = 2 cycles.

Reset
REQ-026 reset=1 SHALL force IDLE, cam_bank=0, finder_bank=0, finder_reset=0, roi_valid=0, roi_data=0, roi_index=0, roi_last=0, frame_complete=0, drop_count=0, timeout_err=0, watchdog counter=0.
REQ-027 reset mid-stream SHALL abort the frame without completing the handshake; frame_done during reset SHALL be ignored and not counted.

Configuration
REQ-028 With ROI_SEQ_WATCHDOG_EN defined: a counter SHALL run in ANALYZE; on reaching TIMEOUT_CYCLES without armed analysis_rdy, timeout_err<=1 (sticky until reset), next state DONE with no ROIs sent.
REQ-029 Without ROI_SEQ_WATCHDOG_EN: no counter SHALL be built, ANALYZE waits indefinitely, timeout_err tied 0.

Verification
REQ-030 frame_done in IDLE; analysis_rdy 1 after 50 cycles, num_rois=3, roi_ready=1 -> finder_reset pulse, 3 beats index 0,1,2, roi_last on index 2, frame_complete, cam_bank=1, finder_bank=0.
REQ-031 analysis_rdy held 1 from prior frame, then 0 for 2 cycles, then 1 -> LATCH only after the 0->1 sequence.
REQ-032 num_rois=0 -> no roi_valid, frame_complete 2 cycles after analysis_rdy rise; num_rois=12 -> exactly 10 beats.
REQ-033 roi_ready low 5 cycles during beat 1 -> roi_data/roi_index stable; 3 frame_done pulses during SEND -> drop_count=3, banks unchanged.
REQ-034 With ROI_SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=100, analysis_rdy stuck 0 -> timeout_err=1 at cycle 100 of ANALYZE, frame_complete, return to IDLE.
REQ-035 reset asserted during SEND beat 2 -> all outputs at reset values next cycle; next frame_done restarts at bank 0.
